// File: rtl/toggle_cover_pkg.sv
// Shared types and helpers for the toggle-coverage schedulers:
// the cover-index type, the index-compute function and popcount.
package toggle_cover_pkg;

  localparam int IDX_W   = 64;
  localparam int POP_MAX = 1024;

  typedef logic [IDX_W-1:0] cover_idx_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

  function automatic cover_idx_t cover_idx(input cover_idx_t base, input int unsigned g,
                                           input int unsigned b, input int unsigned grp_w);
    return base + (64'(g) * 64'(grp_w)) + 64'(b);
  endfunction

  function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
    int unsigned n;
    n = 32'd0;
    for (int i = 0; i < POP_MAX; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/toggle_cover_rr_pick.sv
// Combinational round-robin picker: first non-empty group starting at rr,
// then the lowest set bit inside that group.
module toggle_cover_rr_pick
  import toggle_cover_pkg::*;
#(
  parameter int NUM_GRP = 4,
  parameter int GRP_W   = 6,
  localparam int RR_W   = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1,
  localparam int B_W    = (GRP_W > 1) ? $clog2(GRP_W) : 1
) (
  input  logic [NUM_GRP*GRP_W-1:0] cand,
  input  logic [RR_W-1:0]          rr,
  output logic                     found,
  output logic [RR_W-1:0]          grp,
  output logic [B_W-1:0]           pick_bit
);

  function automatic logic [B_W-1:0] lowest_bit(input logic [GRP_W-1:0] v);
    logic [B_W-1:0] r;
    r = '0;
    for (int j = GRP_W - 1; j >= 0; j--) begin
      r = v[j] ? B_W'(j) : r;
    end
    return r;
  endfunction

  // Scan groups in rotated order; the first hit wins.
  always_comb begin
    int unsigned      idx;
    logic [GRP_W-1:0] gbits;
    found    = 1'b0;
    grp      = '0;
    pick_bit = '0;
    idx      = 32'd0;
    gbits    = '0;
    for (int i = 0; i < NUM_GRP; i++) begin
      idx   = (32'(rr) + 32'(i)) % 32'(NUM_GRP);
      gbits = cand[idx*GRP_W +: GRP_W];
      if (!found && (gbits != '0)) begin
        found    = 1'b1;
        grp      = RR_W'(idx);
        pick_bit = lowest_bit(gbits);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/toggle_cover_sched.sv
// Toggle-coverage scheduler: records first hits per point and serializes each
// newly covered point onto a one-deep valid/ready index stream.
module toggle_cover_sched
  import toggle_cover_pkg::*;
#(
  parameter int          NUM_GRP     = 4,
  parameter int          GRP_W       = 6,
  parameter logic [63:0] COVER_INDEX = 64'd0,
  parameter logic [63:0] COVER_TOTAL = 64'd28338,
  localparam int N     = NUM_GRP * GRP_W,
  localparam int CNT_W = $clog2(N + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [N-1:0]     valid,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [CNT_W-1:0] hit_count,
  output logic             all_covered
);

  localparam int RR_W = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
  localparam int B_W  = (GRP_W > 1) ? $clog2(GRP_W) : 1;
  localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

  if ((COVER_INDEX + 64'(N)) > COVER_TOTAL) begin : g_range_check
    $error("toggle_cover_sched: cover range exceeds COVER_TOTAL");
  end
  if (N > POP_MAX) begin : g_pop_check
    $error("toggle_cover_sched: point count exceeds popcount width");
  end

  out_state_t       state_r, state_nxt_s;
  logic [N-1:0]     seen_r, pend_r;
  logic [RR_W-1:0]  rr_r;
  logic [IDX_W-1:0] out_index_r;
  logic [CNT_W-1:0] hit_count_r;
  logic             all_covered_r;

  logic [N-1:0]     hits_s, seen_base_s, pend_base_s, new_s, cand_s;
  logic [N-1:0]     pick_mask_s, seen_nxt_s, pend_nxt_s;
  logic [CNT_W-1:0] cnt_base_s, cnt_nxt_s;
  logic             pick_found_s, load_s;
  logic [RR_W-1:0]  pick_grp_s, rr_nxt_s;
  logic [B_W-1:0]   pick_bit_s;
  int unsigned      pick_pos_s;

  // A clear wipes history first, so same-cycle hits count as new again.
  assign hits_s      = en ? valid : '0;
  assign seen_base_s = clear ? '0 : seen_r;
  assign pend_base_s = clear ? '0 : pend_r;
  assign cnt_base_s  = clear ? '0 : hit_count_r;
  assign new_s       = hits_s & ~seen_base_s;
  assign cand_s      = pend_base_s | new_s;

  toggle_cover_rr_pick #(
    .NUM_GRP (NUM_GRP),
    .GRP_W   (GRP_W)
  ) u_pick (
    .cand     (cand_s),
    .rr       (rr_r),
    .found    (pick_found_s),
    .grp      (pick_grp_s),
    .pick_bit (pick_bit_s)
  );

  assign pick_pos_s  = (32'(pick_grp_s) * 32'(GRP_W)) + 32'(pick_bit_s);
  assign pick_mask_s = load_s ? (ONE_N << pick_pos_s) : '0;
  assign seen_nxt_s  = seen_base_s | new_s;
  assign pend_nxt_s  = cand_s & ~pick_mask_s;
  assign cnt_nxt_s   = cnt_base_s + CNT_W'(popcount(POP_MAX'(new_s)));
  assign rr_nxt_s    = (pick_grp_s == RR_W'(NUM_GRP - 1)) ? '0 : (pick_grp_s + RR_W'(1));

  // Output-register FSM: decide whether to load a new index this cycle.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (pick_found_s) begin
          load_s      = 1'b1;
          state_nxt_s = ST_FULL;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          load_s      = pick_found_s;
          state_nxt_s = pick_found_s ? ST_FULL : ST_EMPTY;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: begin
        state_nxt_s = ST_EMPTY;
      end
    endcase
  end

  // State, bitmaps, counters and the output register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_EMPTY;
      seen_r        <= '0;
      pend_r        <= '0;
      rr_r          <= '0;
      out_index_r   <= '0;
      hit_count_r   <= '0;
      all_covered_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      seen_r        <= seen_nxt_s;
      pend_r        <= pend_nxt_s;
      hit_count_r   <= cnt_nxt_s;
      all_covered_r <= (cnt_nxt_s == CNT_W'(N));
      if (load_s) begin
        out_index_r <= cover_idx(COVER_INDEX, 32'(pick_grp_s), 32'(pick_bit_s), 32'(GRP_W));
        rr_r        <= rr_nxt_s;
      end else begin
        out_index_r <= out_index_r;
        rr_r        <= rr_r;
      end
    end
  end

  assign out_valid   = (state_r == ST_FULL);
  assign out_index   = out_index_r;
  assign hit_count   = hit_count_r;
  assign all_covered = all_covered_r;

endmodule

// File: tb/tb_toggle_cover_sched.sv
// Directed bench for toggle_cover_sched (4 groups x 6 bits, base index 100).
module tb_toggle_cover_sched;

  logic        clock;
  logic        reset;
  logic        en;
  logic [23:0] valid;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_index;
  logic [4:0]  hit_count;
  logic        all_covered;

  int vectors;
  int miscompares;

  toggle_cover_sched #(
    .NUM_GRP     (4),
    .GRP_W       (6),
    .COVER_INDEX (64'd100),
    .COVER_TOTAL (64'd28338)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .en          (en),
    .valid       (valid),
    .clear       (clear),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_index   (out_index),
    .hit_count   (hit_count),
    .all_covered (all_covered)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    en          = 1'b0;
    valid       = 24'h000000;
    clear       = 1'b0;
    out_ready   = 1'b0;

    tick();
    tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_index", out_index, 64'd0);
    chk("rst_hits", 64'(hit_count), 64'd0);
    chk("rst_allcov", 64'(all_covered), 64'd0);
    reset = 1'b1;

    // hits while disabled are ignored
    valid     = 24'hFFFFFF;
    en        = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("engate_valid", 64'(out_valid), 64'd0);
    chk("engate_hits", 64'(hit_count), 64'd0);

    // full burst drains group-interleaved
    en    = 1'b1;
    valid = 24'hFFFFFF;
    tick();
    valid = 24'h000000;
    chk("burst_hits", 64'(hit_count), 64'd24);
    chk("burst_allcov", 64'(all_covered), 64'd1);
    for (int k = 0; k < 24; k++) begin
      chk("burst_valid", 64'(out_valid), 64'd1);
      chk("burst_index", out_index, 64'(100 + (k % 4) * 6 + (k / 4)));
      tick();
    end
    chk("burst_done", 64'(out_valid), 64'd0);

    // backpressure with bits 0 and 23, re-armed by clear
    out_ready = 1'b0;
    clear     = 1'b1;
    valid     = 24'h800001;
    tick();
    clear = 1'b0;
    valid = 24'h000000;
    chk("bp_hits", 64'(hit_count), 64'd2);
    chk("bp_allcov", 64'(all_covered), 64'd0);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_index", out_index, 64'd100);
      tick();
    end
    chk("bp_last_index", out_index, 64'd100);
    out_ready = 1'b1;
    tick();
    chk("bp_second_valid", 64'(out_valid), 64'd1);
    chk("bp_second_index", out_index, 64'd123);
    tick();
    chk("bp_done", 64'(out_valid), 64'd0);

    // bit 3 reported, then clear with a bit-3 hit reports it again
    valid = 24'h000008;
    tick();
    valid = 24'h000000;
    chk("clr_first_valid", 64'(out_valid), 64'd1);
    chk("clr_first_index", out_index, 64'd103);
    chk("clr_first_hits", 64'(hit_count), 64'd3);
    tick();
    chk("clr_gap", 64'(out_valid), 64'd0);
    clear = 1'b1;
    valid = 24'h000008;
    tick();
    clear = 1'b0;
    valid = 24'h000000;
    chk("clr_again_valid", 64'(out_valid), 64'd1);
    chk("clr_again_index", out_index, 64'd103);
    chk("clr_again_hits", 64'(hit_count), 64'd1);
    tick();
    chk("clr_done", 64'(out_valid), 64'd0);

    // single hit on bit 9, then a repeat that must not re-emit
    valid = 24'h000200;
    tick();
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_index", out_index, 64'd109);
    chk("single_hits", 64'(hit_count), 64'd2);
    tick();
    valid = 24'h000000;
    chk("repeat_valid", 64'(out_valid), 64'd0);
    chk("repeat_hits", 64'(hit_count), 64'd2);
    tick();
    chk("repeat_quiet", 64'(out_valid), 64'd0);

    // asynchronous reset while an index is held
    out_ready = 1'b0;
    valid     = 24'h008000;
    tick();
    valid = 24'h000000;
    chk("mid_valid", 64'(out_valid), 64'd1);
    chk("mid_index", out_index, 64'd115);
    chk("mid_hits", 64'(hit_count), 64'd3);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_index", out_index, 64'd0);
    chk("arst_hits", 64'(hit_count), 64'd0);
    chk("arst_allcov", 64'(all_covered), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_quiet", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    valid     = 24'h000200;
    tick();
    valid = 24'h000000;
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_index", out_index, 64'd109);
    chk("post_rst_hits", 64'(hit_count), 64'd1);
    tick();
    chk("post_rst_done", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/toggle_cover_sched.md
# toggle_cover_sched

Collects toggle-coverage hits from NUM_GRP groups of GRP_W-bit valid vectors, filters out points already reported, and serializes each newly covered point onto a single valid/ready index stream, one index per cycle. It sits between the per-signal toggle probes and the coverage sink (DPI bridge, trace FIFO or formal monitor), where per-bit DPI calls are unavailable or too costly. It also tracks distinct-hit count and full coverage.

## Interface
- NUM_GRP, 4: number of requester groups.
- GRP_W, 6: valid bits per group.
- COVER_INDEX, 0: global index of group 0 bit 0; point (g,b) maps to COVER_INDEX + g*GRP_W + b.
- COVER_TOTAL, 28338: design-wide point count; used only for the elaboration check COVER_INDEX + NUM_GRP*GRP_W <= COVER_TOTAL.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low; the block is in reset while reset==0.
- en  in  1  sampling enable; hits are ignored while en==0.
- valid  in  NUM_GRP*GRP_W  toggle hits; bit g*GRP_W+b belongs to group g, point b.
- clear  in  1  synchronous re-arm of the seen/pending state.
- out_valid  out  1  out_index holds a new point.
- out_ready  in  1  sink accepts this cycle.
- out_index  out  64  global cover index.
- hit_count  out  $clog2(NUM_GRP*GRP_W+1)  distinct points seen since reset/clear.
- all_covered  out  1  hit_count == NUM_GRP*GRP_W.

## Operation
- State: seen bitmap S, pending bitmap P (NUM_GRP*GRP_W bits each), round-robin pointer rr (0..NUM_GRP-1), output register {out_valid, out_index}.
- new = en ? (valid & ~S) : 0. Sample updates: S |= new, P |= new, hit_count += popcount(new).
- Output register FSM, EMPTY (out_valid=0) / FULL (out_valid=1). The register may load when EMPTY, or when FULL with out_ready=1.
- Candidate set C = P | new. The combinational new term gives same-cycle forwarding.
- Pick: first group g scanning rr, rr+1, … (mod NUM_GRP) with C[g] != 0, then the lowest set bit b of that group.
- On load: out_index <= COVER_INDEX + g*GRP_W + b; clear P bit (g,b); rr <= (g+1) mod NUM_GRP; out_valid <= 1.
- No load possible and C empty: FULL with out_ready=1 goes to EMPTY. Otherwise the FSM holds.
- While FULL and out_ready=0, out_index stays stable and P keeps accumulating. No hit is ever dropped.
- clear=1: S, P, hit_count are zeroed first, then that cycle's hits are applied (S = P = valid&{en}). The output register and rr are unaffected, and a held index still completes.
- Each point is emitted at most once between resets/clears.

## Timing
- Reset values: out_valid=0, out_index=0, hit_count=0, all_covered=0, S=P=0, rr=0.
- Latency: a hit sampled at edge k with the register free gives out_valid=1 after edge k (1 cycle).
- Throughput: 1 index per cycle while out_ready=1.
- Worst-case drain of a full simultaneous burst: NUM_GRP*GRP_W cycles.
- rr fairness: a group with pending bits waits at most NUM_GRP-1 emissions.
- all_covered is registered from hit_count and is valid in the same cycle as hit_count.
- Asynchronous reset mid-transfer discards the held index. The sink must tolerate this.

## Structure
- Package toggle_cover_pkg holds:
  - IDX_W=64, the cover-index type;
  - the index-compute function (base, g, b, GRP_W);
  - the popcount function.
- Sub-module toggle_cover_rr_pick is combinational. It takes C and rr and returns {found, g, b}. It is reusable by other cover-type schedulers.

## Test plan
Defaults: NUM_GRP=4, GRP_W=6, COVER_INDEX=100.
- Single hit: valid bit 9 for one cycle, out_ready=1. Required response: out_index=109 on the next cycle, hit_count=1; a repeat of bit 9 produces no further output.
- Burst: all 24 bits in one cycle, out_ready=1. Required response: 24 consecutive indices in order 100,106,112,118,101,107,113,119,… ; hit_count=24 at once; all_covered=1; then out_valid=0.
- Backpressure: hits on bits 0 and 23, out_ready=0 for 5 cycles. Required response: out_valid=1 with out_index=100 held steady; after ready rises, 100 then 123.
- en gating: valid=all ones with en=0. Required response: nothing emitted, hit_count stays 0.
- Clear: after bit 3 is reported, assert clear together with a bit-3 hit. Required response: hit_count=1, and index 103 is emitted again.
- Reset: reset=0 while out_valid=1. Required response: all outputs return to reset values immediately, with no output until new hits arrive.
